// File: rtl/conv_pkg.sv
// Shared definitions for the conv engine weight path: widths, kernel geometry and
// the weight-load state encoding used by the writer and the engine's weight reader.
package conv_pkg;

  localparam int WEIGHT_W    = 16;
  localparam int WADDR_W     = 12;
  localparam int KERNEL_TAPS = 25;
  localparam int KCNT_W      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } wr_state_t;

endpackage

// File: rtl/weight_ram_writer_if.sv
// Valid/ready weight stream from the host/DMA into the weight RAM writer.
interface weight_ram_writer_if import conv_pkg::*; #(
  parameter int DATA_WIDTH = WEIGHT_W
);

  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/weight_tap_counter.sv
// Tap/kernel position counters for a weight load, plus the RAM write address
// (base + beat count, wrapping modulo the RAM depth) and the final-beat flag.
module weight_tap_counter import conv_pkg::*; #(
  parameter int ADDR_WIDTH = WADDR_W,
  parameter int KCNT_WIDTH = KCNT_W,
  parameter int TAPS       = KERNEL_TAPS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [KCNT_WIDTH-1:0] num_kernels,
  output logic [4:0]            tap_cnt,
  output logic [KCNT_WIDTH-1:0] kern_cnt,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  is_final
);

  localparam logic [4:0] LAST_TAP = 5'(TAPS - 1);

  logic [ADDR_WIDTH:0] beat_cnt;
  logic                tap_wrap;

  assign tap_wrap = (tap_cnt == LAST_TAP);
  assign is_final = tap_wrap && (kern_cnt == (num_kernels - KCNT_WIDTH'(1)));
  assign wr_addr  = ADDR_WIDTH'({1'b0, base_addr} + beat_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      tap_cnt  <= '0;
      kern_cnt <= '0;
      beat_cnt <= '0;
    end else if (advance) begin
      beat_cnt <= beat_cnt + (ADDR_WIDTH + 1)'(1);
      if (tap_wrap) begin
        tap_cnt  <= '0;
        kern_cnt <= kern_cnt + KCNT_WIDTH'(1);
      end else begin
        tap_cnt  <= tap_cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/weight_ram_writer.sv
// Streams num_kernels x 25 weights into the kernel weight RAM from base_addr,
// one write per accepted beat with a single cycle of latency.
module weight_ram_writer import conv_pkg::*; #(
  parameter int DATA_WIDTH  = conv_pkg::WEIGHT_W,
  parameter int ADDR_WIDTH  = conv_pkg::WADDR_W,
  parameter int KERNEL_TAPS = conv_pkg::KERNEL_TAPS,
  parameter int KCNT_WIDTH  = conv_pkg::KCNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [KCNT_WIDTH-1:0] num_kernels,
  weight_ram_writer_if.slave    s_if,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  busy,
  output logic                  done,
  output logic                  err_last,
  output logic [KCNT_WIDTH-1:0] kernel_idx,
  output logic [4:0]            tap_idx
);

  wr_state_t state, state_nxt;

  logic                  accept;
  logic                  start_ok;
  logic                  is_final;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [KCNT_WIDTH-1:0] nk_q;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [4:0]            tap_cnt;
  logic [KCNT_WIDTH-1:0] kern_cnt;

  assign start_ok = start && (state == IDLE);
  assign accept   = s_if.s_valid && s_if.s_ready;

  weight_tap_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .KCNT_WIDTH (KCNT_WIDTH),
    .TAPS       (KERNEL_TAPS)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start_ok),
    .advance     (accept),
    .base_addr   (base_q),
    .num_kernels (nk_q),
    .tap_cnt     (tap_cnt),
    .kern_cnt    (kern_cnt),
    .wr_addr     (wr_addr),
    .is_final    (is_final)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start && (num_kernels != '0)) state_nxt = LOAD;
      LOAD: if (accept && is_final)           state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  // Ready is a pure state decode so upstream never sees a valid->ready loop.
  always_comb begin
    s_if.s_ready = (state == LOAD);
    busy         = (state == LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_ena    <= 1'b0;
      ram_wea    <= 1'b0;
      ram_addra  <= '0;
      ram_dina   <= '0;
      done       <= 1'b0;
      err_last   <= 1'b0;
      kernel_idx <= '0;
      tap_idx    <= '0;
      base_q     <= '0;
      nk_q       <= '0;
    end else begin
      ram_ena <= accept;
      ram_wea <= accept;
      done    <= (accept && is_final) || (start_ok && (num_kernels == '0));
      if (start_ok) begin
        base_q <= base_addr;
        nk_q   <= num_kernels;
      end
      if (accept) begin
        ram_addra  <= wr_addr;
        ram_dina   <= s_if.s_data;
        kernel_idx <= kern_cnt;
        tap_idx    <= tap_cnt;
      end
      // The load always completes by count; a misplaced s_last only raises the flag.
      if (start_ok)                                    err_last <= 1'b0;
      else if (accept && (s_if.s_last != is_final))    err_last <= 1'b1;
    end
  end

endmodule
